// File: rtl/uc_arbitro_serial_pkg.sv
// Shared definitions for the serial-transmitter arbiter: state encodings,
// debug width and default sizing.
package uc_arbitro_serial_pkg;

  localparam int unsigned DbW            = 4;
  localparam int unsigned NReqDefault    = 4;
  localparam int unsigned DataWDefault   = 8;
  localparam int unsigned TimeoutDefault = 1023;

  typedef enum logic [DbW-1:0] {
    Ocioso     = 4'd0,
    Arbitra    = 4'd1,
    EsperaByte = 4'd2,
    Envia      = 4'd3,
    AguardaTx  = 4'd4,
    Libera     = 4'd5,
    Erro       = 4'd15
  } estado_t;

  // Width of a requester index; never zero so a 1-bit index still exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uc_arbitro_serial_seletor_round_robin.sv
// Combinational round-robin pick: first requester with req set, scanning
// upward from the one after ptr and wrapping around.
module uc_arbitro_serial_seletor_round_robin
  import uc_arbitro_serial_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  localparam int unsigned IdxW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [IdxW-1:0]  idx,
  output logic             achou
);

  logic [IdxW-1:0] cand;

  always_comb begin
    idx   = '0;
    achou = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IdxW'((32'(ptr) + off) % N_REQ);
      if (!achou && req[cand]) begin
        achou = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uc_arbitro_serial.sv
// Grants the single serial transmitter per packet in round-robin order and
// moves bytes from the granted requester to the transmitter one at a time.
module uc_arbitro_serial
  import uc_arbitro_serial_pkg::*;
#(
  parameter int unsigned N_REQ   = NReqDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        valido,
  input  logic [N_REQ-1:0]        ultimo,
  input  logic [N_REQ*DATA_W-1:0] dados,
  output logic [N_REQ-1:0]        concedido,
  output logic [N_REQ-1:0]        aceito,
  output logic                    tx_partida,
  output logic [DATA_W-1:0]       tx_dado,
  input  logic                    tx_fim,
  output logic                    erro_timeout,
  output logic [DbW-1:0]          db_estado
);

  localparam int unsigned IdxW = idx_width(N_REQ);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  estado_t           estado_q, estado_d;
  logic [IdxW-1:0]   g_q, g_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic              ultimo_q, ultimo_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [IdxW-1:0]   sel_idx;
  logic              sel_achou;
  logic [N_REQ-1:0]  gmask;
  logic              valido_g, req_g, ultimo_g;
  logic [DATA_W-1:0] byte_sel;

  uc_arbitro_serial_seletor_round_robin #(
    .N_REQ (N_REQ)
  ) u_seletor (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (sel_idx),
    .achou (sel_achou)
  );

  // Everything about the granted requester is read through its one-hot mask.
  assign gmask    = N_REQ'(1) << g_q;
  assign valido_g = |(valido & gmask);
  assign req_g    = |(req & gmask);
  assign ultimo_g = |(ultimo & gmask);

  always_comb begin
    byte_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (g_q == IdxW'(i)) begin
        byte_sel = dados[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    estado_d     = estado_q;
    g_d          = g_q;
    ptr_d        = ptr_q;
    dado_d       = dado_q;
    ultimo_d     = ultimo_q;
    cnt_d        = '0;
    concedido    = '0;
    aceito       = '0;
    tx_partida   = 1'b0;
    erro_timeout = 1'b0;

    case (estado_q)
      Ocioso: begin
        if (|req) estado_d = Arbitra;
      end
      Arbitra: begin
        if (sel_achou) begin
          g_d      = sel_idx;
          estado_d = EsperaByte;
        end else begin
          estado_d = Ocioso;
        end
      end
      EsperaByte: begin
        concedido = gmask;
        cnt_d     = cnt_q + 1'b1;
        // A byte on offer wins over a dropped request or an expiring timer.
        if (valido_g) begin
          aceito   = gmask;
          dado_d   = byte_sel;
          ultimo_d = ultimo_g;
          cnt_d    = '0;
          estado_d = Envia;
        end else if (!req_g) begin
          estado_d = Libera;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          erro_timeout = 1'b1;
          estado_d     = Libera;
        end
      end
      Envia: begin
        concedido  = gmask;
        tx_partida = 1'b1;
        estado_d   = AguardaTx;
      end
      AguardaTx: begin
        concedido = gmask;
        if (tx_fim) estado_d = ultimo_q ? Libera : EsperaByte;
      end
      Libera: begin
        ptr_d    = g_q;
        estado_d = Ocioso;
      end
      Erro: begin
        estado_d = Ocioso;
      end
      default: begin
        estado_d = Erro;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= Ocioso;
      g_q      <= '0;
      ptr_q    <= IdxW'(N_REQ - 1);
      dado_q   <= '0;
      ultimo_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      g_q      <= g_d;
      ptr_q    <= ptr_d;
      dado_q   <= dado_d;
      ultimo_q <= ultimo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tx_dado   = dado_q;
  assign db_estado = estado_q;

endmodule
